// File: rtl/diff_to_gray_encoder_seq.sv
// diff_to_gray_encoder_seq
//
// Builds a running gray-code state from a stream of one-hot select words and
// emits it once per accepted step. Steps are grouped into frames of FRAME_LEN
// steps. Each frame begins with a start pulse.
//
// Select word encoding: bit 0 = no change; bit k = toggle gray bit k-1.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_start      frame start / restart pulse (wins over in_valid)
//   in_valid      select word valid
//   in_sel_TP     one-hot select word
//   out_ready     high while a frame is running (registered state decode)
//   out_GC        registered gray-code state
//   out_GC_valid  pulse one cycle after each accepted step
//   out_err       pulse with out_GC_valid when the accepted word was not one-hot
//   out_done      pulse with out_GC_valid for the last step of a frame
//   out_step_cnt  accepted steps in the current frame
//   out_chk_err   self-check mismatch pulse (0 unless the option is enabled)
//
// Optional feature macro: GRAY_ENC_SELFCHECK_EN
//   When defined, the register update is re-checked. The change in out_GC is
//   re-encoded to a select word and compared with the accepted word.
module diff_to_gray_encoder_seq #(
    parameter int unsigned GC_LEN     = 2,
    parameter int unsigned SEL_LENGTH = 3,
    parameter int unsigned FRAME_LEN  = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_start,
    input  logic                  in_valid,
    input  logic [SEL_LENGTH-1:0] in_sel_TP,
    output logic                  out_ready,
    output logic [GC_LEN-1:0]     out_GC,
    output logic                  out_GC_valid,
    output logic                  out_err,
    output logic                  out_done,
    output logic [CNT_W-1:0]      out_step_cnt,
    output logic                  out_chk_err
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q;
    logic [GC_LEN-1:0] gc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              valid_q;
    logic              err_q;
    logic              done_q;

    logic accept;
    logic legal;
    logic last_step;

    assign out_ready = (state_q == StRun);

    // A start in the same cycle drops the word.
    assign accept    = out_ready & in_valid & ~in_start;
    // Exactly one bit set: non-zero, and clearing the lowest set bit gives zero.
    assign legal     = (|in_sel_TP) && ((in_sel_TP & (in_sel_TP - 1'b1)) == '0);
    assign last_step = (cnt_q == CNT_W'(FRAME_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gc_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_start) begin
                        state_q <= StRun;
                        gc_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                StRun: begin
                    if (in_start) begin
                        gc_q  <= '0;
                        cnt_q <= '0;
                    end else if (accept) begin
                        valid_q <= 1'b1;
                        err_q   <= ~legal;
                        // Bit 0 contributes nothing, so a no-change word XORs zero.
                        if (legal) gc_q <= gc_q ^ in_sel_TP[SEL_LENGTH-1:1];
                        cnt_q <= cnt_q + 1'b1;
                        if (last_step) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_GC       = gc_q;
    assign out_GC_valid = valid_q;
    assign out_err      = err_q;
    assign out_done     = done_q;
    assign out_step_cnt = cnt_q;

`ifdef GRAY_ENC_SELFCHECK_EN
    // Keep the pre-update state and the accepted word. The check then uses the
    // register contents after the update, not the value computed for the write.
    logic [GC_LEN-1:0]     prev_q;
    logic [SEL_LENGTH-1:0] sel_q;
    logic [GC_LEN-1:0]     diff;
    logic [SEL_LENGTH-1:0] resel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            sel_q  <= '0;
        end else if (accept) begin
            prev_q <= gc_q;
            sel_q  <= in_sel_TP;
        end
    end

    // Decoder equations: bit k set when diff is exactly gray bit k-1, and
    // bit 0 set otherwise (including a multi-bit diff).
    always_comb begin
        diff  = prev_q ^ gc_q;
        resel = '0;
        for (int k = 1; k < int'(SEL_LENGTH); k++) begin
            resel[k] = (diff == (GC_LEN'(1) << (k - 1)));
        end
        resel[0] = ~|resel[SEL_LENGTH-1:1];
    end

    assign out_chk_err = valid_q & ~err_q & (resel != sel_q);
`else
    assign out_chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_diff_to_gray_encoder_seq.sv
module tb_diff_to_gray_encoder_seq;

    localparam int GC_LEN     = 2;
    localparam int SEL_LENGTH = 3;
    localparam int FRAME_LEN  = 4;
    localparam int CNT_W      = 3;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_start = 1'b0;
    logic                  in_valid = 1'b0;
    logic [SEL_LENGTH-1:0] in_sel_TP = '0;
    logic                  out_ready;
    logic [GC_LEN-1:0]     out_GC;
    logic                  out_GC_valid;
    logic                  out_err;
    logic                  out_done;
    logic [CNT_W-1:0]      out_step_cnt;
    logic                  out_chk_err;

    diff_to_gray_encoder_seq #(
        .GC_LEN    (GC_LEN),
        .SEL_LENGTH(SEL_LENGTH),
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_start    (in_start),
        .in_valid    (in_valid),
        .in_sel_TP   (in_sel_TP),
        .out_ready   (out_ready),
        .out_GC      (out_GC),
        .out_GC_valid(out_GC_valid),
        .out_err     (out_err),
        .out_done    (out_done),
        .out_step_cnt(out_step_cnt),
        .out_chk_err (out_chk_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame flag, gray state as an integer, step count.
    typedef struct {
        int err;
        int done;
        int gc;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   m_run = 0;
    int   m_gc  = 0;
    int   m_cnt = 0;

    // Drive one cycle of stimulus and predict its effect at the next rising edge.
    task automatic step(input logic st, input logic v, input logic [SEL_LENGTH-1:0] s);
        exp_t e;
        int   ones;
        @(negedge clk);
        in_start  = st;
        in_valid  = v;
        in_sel_TP = s;
        if (st) begin
            m_run = 1;
            m_gc  = 0;
            m_cnt = 0;
        end else if (m_run == 1 && v) begin
            ones = $countones(s);
            if (ones == 1) begin
                for (int k = 1; k < SEL_LENGTH; k++) if (s[k]) m_gc = m_gc ^ (1 << (k - 1));
            end
            m_cnt  = m_cnt + 1;
            e.err  = (ones != 1) ? 1 : 0;
            e.done = (m_cnt == FRAME_LEN) ? 1 : 0;
            e.gc   = m_gc;
            e.cnt  = m_cnt;
            if (e.done == 1) m_run = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    // Assert reset between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        in_start = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        m_run = 0;
        m_gc  = 0;
        m_cnt = 0;
        #1;
        chk("async_rst_ready", out_ready, 0);
        chk("async_rst_gc", out_GC, 0);
        chk("async_rst_valid", out_GC_valid, 0);
        chk("async_rst_err", out_err, 0);
        chk("async_rst_done", out_done, 0);
        chk("async_rst_cnt", out_step_cnt, 0);
        chk("async_rst_chk", out_chk_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares after every rising edge, away from it.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (rst_n) begin
            chk("ready", out_ready, m_run);
            chk("gc_state", out_GC, m_gc);
            chk("step_cnt", out_step_cnt, m_cnt);
            chk("chk_err", out_chk_err, 0);
            if (out_GC_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_gc", out_GC, e.gc);
                    chk("pulse_err", out_err, e.err);
                    chk("pulse_done", out_done, e.done);
                    chk("pulse_cnt", out_step_cnt, e.cnt);
                end
            end else begin
                chk("missing_valid", exp_q.size(), 0);
                exp_q.delete();
                chk("err_no_valid", out_err, 0);
                chk("done_no_valid", out_done, 0);
            end
        end
    end

    initial begin
        #3;
        chk("rst_ready", out_ready, 0);
        chk("rst_gc", out_GC, 0);
        chk("rst_cnt", out_step_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Toggle sequence 01,11,10,00 with done on the fourth step.
        step(1'b1, 1'b0, 3'b000);
        step(1'b0, 1'b1, 3'b010);
        step(1'b0, 1'b1, 3'b100);
        step(1'b0, 1'b1, 3'b010);
        step(1'b0, 1'b1, 3'b100);
        idle(2);
        chk("s2_final_gc", out_GC, 0);
        chk("s2_final_cnt", out_step_cnt, FRAME_LEN);
        chk("s2_final_ready", out_ready, 0);

        // No-change words mixed with one toggle.
        step(1'b1, 1'b0, 3'b000);
        step(1'b0, 1'b1, 3'b001);
        step(1'b0, 1'b1, 3'b010);
        step(1'b0, 1'b1, 3'b001);
        step(1'b0, 1'b1, 3'b001);
        idle(2);
        chk("s3_final_gc", out_GC, 1);

        // Illegal words count as steps and hold the state.
        step(1'b1, 1'b0, 3'b000);
        step(1'b0, 1'b1, 3'b000);
        step(1'b0, 1'b1, 3'b110);
        step(1'b0, 1'b1, 3'b100);
        step(1'b0, 1'b1, 3'b111);
        idle(2);
        chk("s4_final_gc", out_GC, 2);

        // Valid ignored in idle; restart drops a simultaneous word.
        step(1'b0, 1'b1, 3'b010);
        step(1'b0, 1'b1, 3'b010);
        step(1'b1, 1'b1, 3'b010);
        step(1'b0, 1'b1, 3'b010);
        step(1'b0, 1'b1, 3'b100);
        step(1'b1, 1'b1, 3'b010);
        idle(1);
        chk("s5_restart_gc", out_GC, 0);
        chk("s5_restart_cnt", out_step_cnt, 0);
        chk("s5_restart_ready", out_ready, 1);
        step(1'b0, 1'b1, 3'b100);
        step(1'b0, 1'b1, 3'b100);
        step(1'b0, 1'b1, 3'b010);
        step(1'b0, 1'b1, 3'b001);
        idle(2);

        // Reset mid-frame with an accept already scheduled.
        step(1'b1, 1'b0, 3'b000);
        step(1'b0, 1'b1, 3'b010);
        step(1'b0, 1'b1, 3'b100);
        async_reset();
        idle(2);

        // Randomised traffic, biased towards one-hot words.
        for (int i = 0; i < 400; i++) begin
            logic st;
            logic v;
            logic [SEL_LENGTH-1:0] s;
            st = ($urandom_range(0, 11) == 0);
            v  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) s = SEL_LENGTH'($urandom);
            else s = SEL_LENGTH'(1 << $urandom_range(0, SEL_LENGTH - 1));
            step(st, v, s);
            if (i == 200) async_reset();
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/diff_to_gray_encoder_seq.md
Name: diff_to_gray_encoder_seq

Overview:
Sequential counterpart of the 2-bit gray-to-3-case select decoder.
- Consumes a stream of one-hot test-pattern select words (no change / toggle bit 0 / toggle bit 1).
- Accumulates them into a running gray-code state and emits the registered gray code per step.
- Sits in the Chase test-pattern generation path and feeds the gray-code decoder stage.
- Frames of FRAME_LEN steps are started by a start pulse.

Parameters:
GC_LEN, 2, gray code width.
SEL_LENGTH, 3, one-hot select width; must equal GC_LEN+1. Bit 0 = no change; bit k = toggle gray bit k-1.
FRAME_LEN, 4, accepted steps per frame; must be at least 1.
CNT_W, 3, step counter width; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_start  input  1  frame start pulse
in_valid  input  1  select word valid
in_sel_TP  input  SEL_LENGTH  one-hot select word
out_ready  output  1  encoder accepts in_sel_TP this cycle
out_GC  output  GC_LEN  registered gray-code state
out_GC_valid  output  1  one-cycle pulse: out_GC updated for an accepted step
out_err  output  1  one-cycle pulse: accepted word was not one-hot
out_done  output  1  one-cycle pulse: last step of frame
out_step_cnt  output  CNT_W  accepted steps in current frame
out_chk_err  output  1  self-check mismatch pulse (see Optional Feature)

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release): FSM=IDLE. out_GC, out_GC_valid, out_err, out_done, out_step_cnt, out_chk_err and out_ready are all 0.
- FSM states: IDLE and RUN.
- out_ready = 1 only in RUN; it is a registered state decode, not combinational from inputs.
- IDLE:
  - in_start=1 -> RUN, out_GC<=0, step_cnt<=0.
  - in_valid is ignored in IDLE, including when in_start is high in the same cycle.
- RUN, accept when in_valid & out_ready:
  - Legal word (exactly one bit set): out_GC <= out_GC XOR in_sel_TP[SEL_LENGTH-1:1]. Bit 0 set leaves out_GC unchanged.
  - Illegal word (zero bits or more than one bit set): out_GC holds and out_err=1 in the same cycle as out_GC_valid.
  - Illegal words still count as a step.
  - out_GC_valid pulses the cycle after acceptance (latency 1). Back-to-back acceptance gives one pulse per cycle.
  - step_cnt increments on every accept.
  - On the accept where step_cnt==FRAME_LEN-1: next cycle out_done=1 together with out_GC_valid, FSM->IDLE, out_ready falls.
  - out_step_cnt shows FRAME_LEN during the done cycle, then holds until the next start.
- RUN, in_start=1: restart. out_GC<=0, step_cnt<=0, stay in RUN.
  - Start has priority over a simultaneous in_valid; that word is dropped and no valid pulse follows.
- No accept in a cycle: out_GC holds; out_GC_valid, out_err and out_done are 0.
- out_GC persists in IDLE after done, until the next start.
- Reset mid-frame aborts immediately; pulses already scheduled are cancelled.

Optional Feature:
Macro: GRAY_ENC_SELFCHECK_EN
- Defined:
  - On every accept, the previous and next out_GC are combined as XOR diff = prev ^ next.
  - The diff is re-encoded to a 3-case select using the decoder equations: case1 = d0&~d1, case2 = ~d0&d1, case0 = ~(case1|case2).
  - The re-encoded select is compared with the accepted in_sel_TP.
  - out_chk_err pulses, aligned with out_GC_valid, on a mismatch for a legal word.
  - It is suppressed when out_err=1.
- Not defined: out_chk_err tied to 0, no extra logic.

Test Plan:
1. Assert rst_n=0 mid-stream -> all outputs 0 asynchronously (before the next clk edge). After release: out_ready=0, out_GC=00.
2. in_start, then in_sel_TP=010,100,010,100 back-to-back -> out_GC=01,11,10,00 on consecutive valid pulses. out_done with the 4th pulse, out_step_cnt=4, out_ready=0 afterwards.
3. Start, then 001,010,001,001 -> out_GC=00,01,01,01, all valid, no out_err, done on the 4th.
4. Start, then 000,110,100,111 -> out_err on steps 1, 2 and 4. out_GC=00,00,10,10, done on the 4th.
5. in_valid=1 with sel=010 in IDLE -> no valid pulse. Start plus valid in RUN after 2 steps -> out_GC=00, out_step_cnt=0, word dropped.
6. With GRAY_ENC_SELFCHECK_EN defined: run scenario 2 -> out_chk_err stays 0 throughout. Force internal out_GC corruption -> out_chk_err=1 on that step.
